gp9001_host_port: RTL and testbench

GP9001_HOST_PORT -- requirements
Module: gp9001_host_port

---
 rtl/gp9001_host_port_if.sv | 38 +++
 rtl/gp9001_host_port.sv | 150 +++++++++++++++
 tb/tb_gp9001_host_port.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gp9001_host_port_if.sv
// Host-port bundle for gp9001_host_port: 68k-side request/ack bus plus the VRAM
// and register-file strobes it drives.
interface gp9001_host_port_if #(
  parameter int AW = 14
);
  logic          OP_SELECT_REG;
  logic          OP_WRITE_REG;
  logic          OP_WRITE_RAM;
  logic          OP_READ_RAM_H;
  logic          OP_READ_RAM_L;
  logic          OP_SET_RAM_PTR;
  logic [15:0]   DIN;
  logic [1:0]    BE;
  logic          ACK;
  logic [15:0]   DOUT;
  logic [7:0]    REG_INDEX;
  logic [15:0]   REG_WDATA;
  logic          REG_WE;
  logic [AW-1:0] VRAM_ADDR;
  logic [15:0]   VRAM_WDATA;
  logic [1:0]    VRAM_WE;
  logic          VRAM_RE;
  logic [15:0]   VRAM_Q;

  modport slave (
    input  OP_SELECT_REG, OP_WRITE_REG, OP_WRITE_RAM, OP_READ_RAM_H,
           OP_READ_RAM_L, OP_SET_RAM_PTR, DIN, BE, VRAM_Q,
    output ACK, DOUT, REG_INDEX, REG_WDATA, REG_WE,
           VRAM_ADDR, VRAM_WDATA, VRAM_WE, VRAM_RE
  );

  modport master (
    output OP_SELECT_REG, OP_WRITE_REG, OP_WRITE_RAM, OP_READ_RAM_H,
           OP_READ_RAM_L, OP_SET_RAM_PTR, DIN, BE, VRAM_Q,
    input  ACK, DOUT, REG_INDEX, REG_WDATA, REG_WE,
           VRAM_ADDR, VRAM_WDATA, VRAM_WE, VRAM_RE
  );
endinterface

// File: rtl/gp9001_host_port.sv
// GP9001 68k host port: four-phase op handshake onto VRAM and register strobes.
// Define GP9001_VRAM_READ_EN to enable VRAM reads (RDWAIT state); otherwise reads return 0.
module gp9001_host_port #(
  parameter int AW = 14
) (
  input  logic               CLK96,
  input  logic               RESET96,
  gp9001_host_port_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PTR,
    OP_SEL,
    OP_WREG,
    OP_WRAM,
    OP_RDH,
    OP_RDL
  } opKind_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
`ifdef GP9001_VRAM_READ_EN
    S_RDWAIT,
`endif
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  opKind_t       r_op;
  opKind_t       w_reqOp;
  logic [15:0]   r_din;
  logic [1:0]    r_be;
  logic [AW-1:0] r_ptr;
  logic [7:0]    r_regIndex;
  logic [15:0]   r_dout;
  logic          r_ack;
  logic          w_anyOp;
  logic [1:0]    w_vramWe;
  logic          w_vramRe;
  logic          w_regWe;

  assign w_anyOp = bus.OP_SET_RAM_PTR | bus.OP_SELECT_REG | bus.OP_WRITE_REG |
                   bus.OP_WRITE_RAM | bus.OP_READ_RAM_H | bus.OP_READ_RAM_L;

  // Only the highest-priority request is taken; the rest are dropped for this transaction.
  always_comb begin
    w_reqOp = OP_NONE;
    if (bus.OP_SET_RAM_PTR)     w_reqOp = OP_PTR;
    else if (bus.OP_SELECT_REG) w_reqOp = OP_SEL;
    else if (bus.OP_WRITE_REG)  w_reqOp = OP_WREG;
    else if (bus.OP_WRITE_RAM)  w_reqOp = OP_WRAM;
    else if (bus.OP_READ_RAM_H) w_reqOp = OP_RDH;
    else if (bus.OP_READ_RAM_L) w_reqOp = OP_RDL;
  end

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) r_state <= S_IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_vramWe    = 2'b00;
    w_vramRe    = 1'b0;
    w_regWe     = 1'b0;
    case (r_state)
      S_IDLE: if (w_anyOp) w_nextState = S_EXEC;
      S_EXEC: begin
        w_nextState = S_DONE;
        case (r_op)
          OP_WREG: w_regWe  = 1'b1;
          OP_WRAM: w_vramWe = r_be;
          OP_RDH, OP_RDL: begin
`ifdef GP9001_VRAM_READ_EN
            w_vramRe    = 1'b1;
            w_nextState = S_RDWAIT;
`endif
          end
          default: ;
        endcase
      end
`ifdef GP9001_VRAM_READ_EN
      S_RDWAIT: w_nextState = S_DONE;
`endif
      S_DONE: if (!w_anyOp) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // ACK is registered off DONE so it lands one edge after the state change.
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      r_op       <= OP_NONE;
      r_din      <= '0;
      r_be       <= '0;
      r_ptr      <= '0;
      r_regIndex <= '0;
      r_dout     <= '0;
      r_ack      <= 1'b0;
    end else begin
      r_ack <= (r_state == S_DONE) && w_anyOp;
      case (r_state)
        S_IDLE: begin
          if (w_anyOp) begin
            r_op  <= w_reqOp;
            r_din <= bus.DIN;
            r_be  <= bus.BE;
          end
        end
        S_EXEC: begin
          case (r_op)
            OP_PTR:  r_ptr      <= r_din[AW-1:0];
            OP_SEL:  r_regIndex <= r_din[7:0];
            OP_WRAM: r_ptr      <= r_ptr + AW'(1);
`ifndef GP9001_VRAM_READ_EN
            OP_RDH, OP_RDL: r_dout <= '0;
`endif
            default: ;
          endcase
        end
`ifdef GP9001_VRAM_READ_EN
        S_RDWAIT: begin
          r_dout <= bus.VRAM_Q;
          if (r_op == OP_RDL) r_ptr <= r_ptr + AW'(1);
        end
`endif
        default: ;
      endcase
    end
  end

`ifndef GP9001_VRAM_READ_EN
  logic w_unusedQ;
  assign w_unusedQ = ^bus.VRAM_Q;
`endif

  assign bus.ACK        = r_ack;
  assign bus.DOUT       = r_dout;
  assign bus.REG_INDEX  = r_regIndex;
  assign bus.REG_WDATA  = r_din;
  assign bus.REG_WE     = w_regWe;
  assign bus.VRAM_ADDR  = r_ptr;
  assign bus.VRAM_WDATA = r_din;
  assign bus.VRAM_WE    = w_vramWe;
  assign bus.VRAM_RE    = w_vramRe;

endmodule

// File: tb/tb_gp9001_host_port.sv
// Directed bench for gp9001_host_port with a one-cycle-latency VRAM read model.
// Expectations follow GP9001_VRAM_READ_EN when it is defined for the build.
module tb_gp9001_host_port;

  localparam int AW = 14;

  localparam logic [5:0] M_PTR  = 6'b100000;
  localparam logic [5:0] M_SEL  = 6'b010000;
  localparam logic [5:0] M_WREG = 6'b001000;
  localparam logic [5:0] M_WRAM = 6'b000100;
  localparam logic [5:0] M_RDH  = 6'b000010;
  localparam logic [5:0] M_RDL  = 6'b000001;

`ifdef GP9001_VRAM_READ_EN
  localparam int          RD_LAT      = 3;
  localparam logic [15:0] RD_DATA     = 16'hA5A5;
  localparam int          RD_INC      = 1;
  localparam int          RD_RE       = 1;
  localparam logic [15:0] RESTART_DAT = 16'h7E57;
`else
  localparam int          RD_LAT      = 2;
  localparam logic [15:0] RD_DATA     = 16'h0000;
  localparam int          RD_INC      = 0;
  localparam int          RD_RE       = 0;
  localparam logic [15:0] RESTART_DAT = 16'h0000;
`endif

  logic CLK96;
  logic RESET96;
  int   checks = 0;
  int   errors = 0;

  int          weCount = 0;
  int          reCount = 0;
  int          regWeCount = 0;
  logic [1:0]  lastWe;
  logic [15:0] lastWeAddr;
  logic [15:0] lastWeData;
  logic [7:0]  lastRegIdx;
  logic [15:0] lastRegData;

  gp9001_host_port_if #(.AW(AW)) hostIf ();

  gp9001_host_port #(.AW(AW)) dut (
    .CLK96   (CLK96),
    .RESET96 (RESET96),
    .bus     (hostIf)
  );

  initial CLK96 = 1'b0;
  always #5 CLK96 = ~CLK96;

  function automatic logic [15:0] vramContent(input logic [AW-1:0] addr);
    if (addr == 14'h0100)      return 16'hA5A5;
    else if (addr == 14'h0000) return 16'h7E57;
    else                       return 16'(addr) ^ 16'h5555;
  endfunction

  // VRAM read port: data appears exactly one cycle after the read strobe.
  always @(posedge CLK96) begin
    if (hostIf.VRAM_RE) hostIf.VRAM_Q <= vramContent(hostIf.VRAM_ADDR);
    else                hostIf.VRAM_Q <= 16'hDEAD;
  end

  // Strobe monitor, sampled mid-cycle so each one-cycle pulse is seen exactly once.
  always @(negedge CLK96) begin
    if (hostIf.VRAM_WE != 2'b00) begin
      weCount    <= weCount + 1;
      lastWe     <= hostIf.VRAM_WE;
      lastWeAddr <= 16'(hostIf.VRAM_ADDR);
      lastWeData <= hostIf.VRAM_WDATA;
    end
    if (hostIf.VRAM_RE) reCount <= reCount + 1;
    if (hostIf.REG_WE) begin
      regWeCount  <= regWeCount + 1;
      lastRegIdx  <= hostIf.REG_INDEX;
      lastRegData <= hostIf.REG_WDATA;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] ops, input logic [15:0] din,
                               input logic [1:0] be);
    @(negedge CLK96);
    {hostIf.OP_SET_RAM_PTR, hostIf.OP_SELECT_REG, hostIf.OP_WRITE_REG,
     hostIf.OP_WRITE_RAM, hostIf.OP_READ_RAM_H, hostIf.OP_READ_RAM_L} = ops;
    hostIf.DIN = din;
    hostIf.BE  = be;
  endtask

  // Latency is counted in edges after the first edge that sees the request.
  task automatic waitAck(output int latency);
    bit seen = 1'b0;
    int i = 0;
    latency = -1;
    while (!seen && i < 12) begin
      @(posedge CLK96); #1;
      if (hostIf.ACK) begin
        seen    = 1'b1;
        latency = i;
      end
      i++;
    end
  endtask

  task automatic releaseOps(input string tag);
    @(negedge CLK96);
    {hostIf.OP_SET_RAM_PTR, hostIf.OP_SELECT_REG, hostIf.OP_WRITE_REG,
     hostIf.OP_WRITE_RAM, hostIf.OP_READ_RAM_H, hostIf.OP_READ_RAM_L} = 6'b0;
    @(posedge CLK96); #1;
    checkOutput(tag, 32'(hostIf.ACK), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int weBase;
    int reBase;
    int regBase;

    RESET96 = 1'b1;
    {hostIf.OP_SET_RAM_PTR, hostIf.OP_SELECT_REG, hostIf.OP_WRITE_REG,
     hostIf.OP_WRITE_RAM, hostIf.OP_READ_RAM_H, hostIf.OP_READ_RAM_L} = 6'b0;
    hostIf.DIN = 16'h0000;
    hostIf.BE  = 2'b00;
    repeat (3) @(posedge CLK96);
    #1;
    checkOutput("rstAck",      32'(hostIf.ACK),        32'd0);
    checkOutput("rstDout",     32'(hostIf.DOUT),       32'd0);
    checkOutput("rstRegIndex", 32'(hostIf.REG_INDEX),  32'd0);
    checkOutput("rstRegWdata", 32'(hostIf.REG_WDATA),  32'd0);
    checkOutput("rstRegWe",    32'(hostIf.REG_WE),     32'd0);
    checkOutput("rstAddr",     32'(hostIf.VRAM_ADDR),  32'd0);
    checkOutput("rstWdata",    32'(hostIf.VRAM_WDATA), 32'd0);
    checkOutput("rstVramWe",   32'(hostIf.VRAM_WE),    32'd0);
    checkOutput("rstVramRe",   32'(hostIf.VRAM_RE),    32'd0);
    @(negedge CLK96);
    RESET96 = 1'b0;

    // Pointer load then full-word write.
    applyStimulus(M_PTR, 16'h1234, 2'b00);
    waitAck(lat);
    checkOutput("ptrLat", 32'(lat), 32'd2);
    releaseOps("ptrAckDrop");
    checkOutput("ptrValue", 32'(hostIf.VRAM_ADDR), 32'h1234);
    weBase = weCount;
    applyStimulus(M_WRAM, 16'hBEEF, 2'b11);
    waitAck(lat);
    checkOutput("wramLat", 32'(lat), 32'd2);
    releaseOps("wramAckDrop");
    checkOutput("wramCount", 32'(weCount - weBase), 32'd1);
    checkOutput("wramWe",    32'(lastWe),           32'd3);
    checkOutput("wramAddr",  32'(lastWeAddr),       32'h1234);
    checkOutput("wramData",  32'(lastWeData),       32'hBEEF);
    checkOutput("wramPtr",   32'(hostIf.VRAM_ADDR), 32'h1235);

    // Low-byte write at the top address wraps the pointer.
    applyStimulus(M_PTR, 16'h3FFF, 2'b00);
    waitAck(lat);
    releaseOps("wrapPtrAckDrop");
    weBase = weCount;
    applyStimulus(M_WRAM, 16'h5A5A, 2'b01);
    waitAck(lat);
    releaseOps("wrapAckDrop");
    checkOutput("wrapCount", 32'(weCount - weBase), 32'd1);
    checkOutput("wrapWe",    32'(lastWe),           32'd1);
    checkOutput("wrapAddr",  32'(lastWeAddr),       32'h3FFF);
    checkOutput("wrapPtr",   32'(hostIf.VRAM_ADDR), 32'h0000);

    // High read keeps the pointer, low read advances it.
    applyStimulus(M_PTR, 16'h0100, 2'b00);
    waitAck(lat);
    releaseOps("rdPtrAckDrop");
    reBase = reCount;
    applyStimulus(M_RDH, 16'h0000, 2'b00);
    waitAck(lat);
    checkOutput("rdhLat",  32'(lat),         32'(RD_LAT));
    checkOutput("rdhDout", 32'(hostIf.DOUT), 32'(RD_DATA));
    releaseOps("rdhAckDrop");
    checkOutput("rdhPtr",  32'(hostIf.VRAM_ADDR), 32'h0100);
    checkOutput("rdhRe",   32'(reCount - reBase), 32'(RD_RE));
    applyStimulus(M_RDL, 16'h0000, 2'b00);
    waitAck(lat);
    checkOutput("rdlLat",  32'(lat),         32'(RD_LAT));
    checkOutput("rdlDout", 32'(hostIf.DOUT), 32'(RD_DATA));
    releaseOps("rdlAckDrop");
    checkOutput("rdlPtr",  32'(hostIf.VRAM_ADDR), 32'(16'h0100 + RD_INC));

    // Register select then register write.
    regBase = regWeCount;
    applyStimulus(M_SEL, 16'h000F, 2'b00);
    waitAck(lat);
    checkOutput("selLat", 32'(lat), 32'd2);
    releaseOps("selAckDrop");
    checkOutput("selIndex", 32'(hostIf.REG_INDEX), 32'h0F);
    applyStimulus(M_WREG, 16'h0123, 2'b00);
    waitAck(lat);
    checkOutput("wregLat", 32'(lat), 32'd2);
    releaseOps("wregAckDrop");
    checkOutput("wregCount", 32'(regWeCount - regBase), 32'd1);
    checkOutput("wregIndex", 32'(lastRegIdx),           32'h0F);
    checkOutput("wregData",  32'(lastRegData),          32'h0123);
    checkOutput("wregKeep",  32'(hostIf.REG_INDEX),     32'h0F);
    checkOutput("doutHold",  32'(hostIf.DOUT),          32'(RD_DATA));

    // Simultaneous requests: pointer load wins, ACK holds until every op drops.
    weBase = weCount;
    applyStimulus(M_PTR | M_WRAM, 16'h0040, 2'b11);
    waitAck(lat);
    checkOutput("prioLat", 32'(lat), 32'd2);
    @(negedge CLK96);
    hostIf.OP_WRITE_RAM = 1'b0;
    repeat (2) @(posedge CLK96);
    #1;
    checkOutput("prioAckHeld", 32'(hostIf.ACK), 32'd1);
    releaseOps("prioAckDrop");
    checkOutput("prioPtr",  32'(hostIf.VRAM_ADDR),  32'h0040);
    checkOutput("prioNoWe", 32'(weCount - weBase),  32'd0);

    regBase = regWeCount;
    applyStimulus(M_SEL | M_WREG, 16'h0022, 2'b00);
    waitAck(lat);
    releaseOps("prio2AckDrop");
    checkOutput("prio2Index", 32'(hostIf.REG_INDEX),     32'h22);
    checkOutput("prio2NoWe",  32'(regWeCount - regBase), 32'd0);

    // Reset in the middle of a read, op held across reset and re-run afterwards.
    weBase  = weCount;
    regBase = regWeCount;
    applyStimulus(M_RDL, 16'h0000, 2'b00);
    repeat (RD_LAT - 1) @(posedge CLK96);
    #2;
    RESET96 = 1'b1;
    #1;
    checkOutput("midRstAck",   32'(hostIf.ACK),       32'd0);
    checkOutput("midRstDout",  32'(hostIf.DOUT),      32'd0);
    checkOutput("midRstIndex", 32'(hostIf.REG_INDEX), 32'd0);
    checkOutput("midRstAddr",  32'(hostIf.VRAM_ADDR), 32'd0);
    checkOutput("midRstRe",    32'(hostIf.VRAM_RE),   32'd0);
    @(negedge CLK96);
    RESET96 = 1'b0;
    waitAck(lat);
    checkOutput("rerunLat",  32'(lat),         32'(RD_LAT));
    checkOutput("rerunDout", 32'(hostIf.DOUT), 32'(RESTART_DAT));
    releaseOps("rerunAckDrop");
    checkOutput("rerunPtr",     32'(hostIf.VRAM_ADDR),     32'(RD_INC));
    checkOutput("rerunNoWe",    32'(weCount - weBase),     32'd0);
    checkOutput("rerunNoRegWe", 32'(regWeCount - regBase), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
